ga_io_write_receiver: RTL and testbench

- Receiving end of the Z80 data-bus interface. The tri-state driver pushes data out; this block captures CPU I/O writes addressed to the gate array.
- Synchronises the Z80 write strobe into the CLK domain. Latches D7..D0 once per write cycle, decodes the function bits, and updates the pen, ink, mode and ROM-control state consumed by the video and memory-control logic.

---
 rtl/ga_pkg.sv | 19 +
 rtl/ga_io_write_receiver_if.sv | 14 +
 rtl/ga_sync.sv | 23 ++
 rtl/ga_io_write_receiver.sv | 107 ++++++++++
 tb/tb_ga_io_write_receiver.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ga_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the gate-array Z80 I/O write path:
// function codes, border pen index and the receiver FSM states.
package ga_pkg;

  localparam logic [1:0] FN_PEN  = 2'b00;
  localparam logic [1:0] FN_INK  = 2'b01;
  localparam logic [1:0] FN_CTRL = 2'b10;
  localparam logic [1:0] FN_RAM  = 2'b11;

  localparam logic [4:0] BORDER_PEN = 5'd16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/ga_io_write_receiver_if.sv
`timescale 1ns/1ps
// Z80 bus signals seen by the gate array write receiver.
// The CPU side drives everything; the receiver only listens.
interface ga_io_write_receiver_if;
  logic [7:0] D;
  logic       A15;
  logic       A14;
  logic       nIORQ;
  logic       nWR;
  logic       nM1;

  modport master (output D, A15, A14, nIORQ, nWR, nM1);
  modport slave  (input  D, A15, A14, nIORQ, nWR, nM1);
endinterface

// File: rtl/ga_sync.sv
`timescale 1ns/1ps
// Multi-flop synchroniser for asynchronous Z80 inputs, with an
// asynchronous active-low clear to a selectable inactive level.
module ga_sync #(
  parameter int   STAGES  = 2,
  parameter logic CLR_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{CLR_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ga_io_write_receiver.sv
`timescale 1ns/1ps
// Captures Z80 I/O writes to the gate array and updates pen, palette,
// mode and ROM-control state for the video and memory logic.
//
// state    | meaning
// IDLE     | waiting for a synchronised write strobe; D is latched on entry to DECODE
// DECODE   | acting on the latched byte for exactly one cycle
// WAIT_REL | holding until the strobe releases so a long strobe is one write
module ga_io_write_receiver
  import ga_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  ga_io_write_receiver_if.slave   bus,
  input  logic                    HSYNC,
  output logic [4:0]              PEN,
  output logic                    INK_WE,
  output logic [4:0]              INK_ADDR,
  output logic [4:0]              INK_DATA,
  output logic [1:0]              MODE,
  output logic                    LROM_DIS,
  output logic                    UROM_DIS,
  output logic                    INT_RESET
);

  logic       wr_raw;
  logic       wr_s;
  state_t     state;
  logic [7:0] dbuf;
  logic [1:0] mode_pend;
  logic       hsync_q;
  logic       unused_dbuf;

  assign wr_raw = ~bus.nIORQ & ~bus.nWR & bus.nM1 & ~bus.A15 & bus.A14;

  ga_sync #(
    .STAGES  (SYNC_STAGES),
    .CLR_VAL (1'b0)
  ) u_wr_sync (
    .clk   (CLK),
    .rst_n (nRESET),
    .d     (wr_raw),
    .q     (wr_s)
  );

  // bit 5 carries no meaning for any function code
  assign unused_dbuf = dbuf[5];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      dbuf      <= 8'd0;
      PEN       <= 5'd0;
      MODE      <= 2'd0;
      mode_pend <= 2'd0;
      LROM_DIS  <= 1'b0;
      UROM_DIS  <= 1'b0;
      INK_WE    <= 1'b0;
      INK_ADDR  <= 5'd0;
      INK_DATA  <= 5'd0;
      INT_RESET <= 1'b0;
      hsync_q   <= 1'b0;
    end else begin
      INK_WE    <= 1'b0;
      INT_RESET <= 1'b0;
      hsync_q   <= HSYNC;

      // a control write in the same cycle only reaches MODE on the next line
      if (HSYNC && !hsync_q) MODE <= mode_pend;

      case (state)
        IDLE: begin
          if (wr_s) begin
            dbuf  <= bus.D;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (dbuf[7:6])
            FN_PEN:  PEN <= dbuf[4] ? BORDER_PEN : {1'b0, dbuf[3:0]};
            FN_INK: begin
              INK_WE   <= 1'b1;
              INK_ADDR <= PEN;
              INK_DATA <= dbuf[4:0];
            end
            FN_CTRL: begin
              mode_pend <= dbuf[1:0];
              LROM_DIS  <= dbuf[2];
              UROM_DIS  <= dbuf[3];
              INT_RESET <= dbuf[4];
            end
            FN_RAM: ;
            default: ;
          endcase
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!wr_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ga_io_write_receiver.sv
`timescale 1ns/1ps
// Directed bench for the gate-array I/O write receiver.
module tb_ga_io_write_receiver;
  import ga_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       nRESET;
  logic       HSYNC;
  logic [4:0] PEN;
  logic       INK_WE;
  logic [4:0] INK_ADDR;
  logic [4:0] INK_DATA;
  logic [1:0] MODE;
  logic       LROM_DIS;
  logic       UROM_DIS;
  logic       INT_RESET;

  ga_io_write_receiver_if bus();

  ga_io_write_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK       (clk),
    .nRESET    (nRESET),
    .bus       (bus),
    .HSYNC     (HSYNC),
    .PEN       (PEN),
    .INK_WE    (INK_WE),
    .INK_ADDR  (INK_ADDR),
    .INK_DATA  (INK_DATA),
    .MODE      (MODE),
    .LROM_DIS  (LROM_DIS),
    .UROM_DIS  (UROM_DIS),
    .INT_RESET (INT_RESET)
  );

  initial clk = 1'b0;
  always #31.25 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int         ink_cnt = 0;
  int         int_cnt = 0;
  int         ink_run = 0;
  int         int_run = 0;
  int         max_run = 0;
  logic [4:0] last_addr = 5'd0;
  logic [4:0] last_data = 5'd0;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (INK_WE === 1'b1) begin
      ink_cnt++;
      ink_run++;
      last_addr = INK_ADDR;
      last_data = INK_DATA;
    end else begin
      ink_run = 0;
    end
    if (INT_RESET === 1'b1) begin
      int_cnt++;
      int_run++;
    end else begin
      int_run = 0;
    end
    if (ink_run > max_run) max_run = ink_run;
    if (int_run > max_run) max_run = int_run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic strobe_on(input logic [7:0] d, input logic a15, input logic m1);
    bus.D     = d;
    bus.A15   = a15;
    bus.A14   = 1'b1;
    bus.nM1   = m1;
    bus.nIORQ = 1'b0;
    bus.nWR   = 1'b0;
  endtask

  task automatic strobe_off();
    bus.nIORQ = 1'b1;
    bus.nWR   = 1'b1;
    bus.nM1   = 1'b1;
    bus.A15   = 1'b1;
    bus.A14   = 1'b0;
  endtask

  task automatic write_io(input logic [7:0] d, input int hold);
    strobe_on(d, 1'b0, 1'b1);
    repeat (hold) tick();
    strobe_off();
    repeat (6) tick();
  endtask

  task automatic hsync_pulse();
    HSYNC = 1'b1;
    tick();
    HSYNC = 1'b0;
    tick();
  endtask

  initial begin
    nRESET = 1'b0;
    HSYNC  = 1'b0;
    bus.D  = 8'h00;
    strobe_off();
    repeat (3) tick();

    chk("rst_pen",       PEN,       0);
    chk("rst_mode",      MODE,      0);
    chk("rst_lrom",      LROM_DIS,  0);
    chk("rst_urom",      UROM_DIS,  0);
    chk("rst_ink_we",    INK_WE,    0);
    chk("rst_int_reset", INT_RESET, 0);
    chk("rst_ink_addr",  INK_ADDR,  0);
    chk("rst_ink_data",  INK_DATA,  0);

    nRESET = 1'b1;
    repeat (2) tick();

    // pen select with exact latency
    strobe_on(8'h03, 1'b0, 1'b1);
    repeat (SYNC_STAGES + 1) tick();
    chk("pen_before_latency", PEN, 0);
    tick();
    chk("pen_at_latency", PEN, 3);
    repeat (6 - (SYNC_STAGES + 2)) tick();
    strobe_off();
    repeat (6) tick();
    chk("pen_no_ink", ink_cnt, 0);

    // ink writes
    write_io(8'h54, 6);
    chk("ink1_count", ink_cnt, 1);
    chk("ink1_addr",  last_addr, 3);
    chk("ink1_data",  last_data, 5'h14);

    write_io(8'h10, 6);
    chk("pen_border", PEN, 16);
    write_io(8'h4B, 6);
    chk("ink2_count", ink_cnt, 2);
    chk("ink2_addr",  last_addr, 16);
    chk("ink2_data",  last_data, 5'h0B);

    // control write
    write_io(8'h9D, 6);
    chk("ctrl_lrom",     LROM_DIS, 1);
    chk("ctrl_urom",     UROM_DIS, 1);
    chk("ctrl_int_cnt",  int_cnt,  1);
    chk("ctrl_mode_old", MODE,     0);
    hsync_pulse();
    chk("mode_after_hsync", MODE, 1);

    // control write decoded on the same edge as an HSYNC rise
    strobe_on(8'h82, 1'b0, 1'b1);
    repeat (SYNC_STAGES + 1) tick();
    HSYNC = 1'b1;
    tick();
    chk("mode_coincident", MODE, 1);
    HSYNC = 1'b0;
    repeat (2) tick();
    strobe_off();
    repeat (6) tick();
    chk("ctrl2_lrom", LROM_DIS, 0);
    chk("ctrl2_urom", UROM_DIS, 0);
    chk("mode_hold_line", MODE, 1);
    hsync_pulse();
    chk("mode_next_line", MODE, 2);

    // qualification
    strobe_on(8'h07, 1'b1, 1'b1);
    repeat (6) tick();
    strobe_off();
    repeat (6) tick();
    chk("a15_ignored", PEN, 16);

    strobe_on(8'h07, 1'b0, 1'b0);
    repeat (6) tick();
    strobe_off();
    repeat (6) tick();
    chk("m1_ignored", PEN, 16);

    write_io(8'hC5, 6);
    chk("ram_pen",     PEN,      16);
    chk("ram_mode",    MODE,     2);
    chk("ram_lrom",    LROM_DIS, 0);
    chk("ram_urom",    UROM_DIS, 0);
    chk("ram_ink_cnt", ink_cnt,  2);
    chk("ram_int_cnt", int_cnt,  1);

    write_io(8'h41, 40);
    chk("held_ink_count", ink_cnt, 3);
    chk("held_ink_addr",  last_addr, 16);
    chk("held_ink_data",  last_data, 5'h01);

    // reset in the middle of an ink write
    write_io(8'h05, 6);
    chk("pen5", PEN, 5);
    write_io(8'h8E, 6);
    chk("pre_rst_lrom", LROM_DIS, 1);

    strobe_on(8'h54, 1'b0, 1'b1);
    repeat (SYNC_STAGES + 2) tick();
    chk("ink_we_pre_reset", INK_WE, 1);
    nRESET = 1'b0;
    #1;
    chk("async_ink_we",  INK_WE,   0);
    chk("async_pen",     PEN,      0);
    chk("async_mode",    MODE,     0);
    chk("async_lrom",    LROM_DIS, 0);
    chk("async_urom",    UROM_DIS, 0);
    chk("async_ink_addr", INK_ADDR, 0);
    repeat (2) tick();
    nRESET = 1'b1;
    repeat (8) tick();
    chk("fresh_ink_count", ink_cnt, 4);
    chk("fresh_ink_addr",  last_addr, 0);
    chk("fresh_ink_data",  last_data, 5'h14);
    strobe_off();
    repeat (6) tick();
    chk("fresh_single", ink_cnt, 4);

    chk("pulse_width", max_run, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
